// File: rtl/ads_frame_reader.sv
// SPI front-end for an ADS1299-class ADC in RDATAC mode: reads one frame per
// DRDY falling edge and emits each channel as a Q2.29 sample with a one-cycle valid.
module ads_frame_reader #(
   parameter int CLK_DIV = 4,
   parameter int NCH     = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        drdy_n,
   input  logic        miso,
   output logic        sclk,
   output logic        cs_n,
   output logic        mosi,
   output logic [31:0] sample,
   output logic [2:0]  ch,
   output logic        valid,
   output logic [23:0] status,
   output logic        frame_done,
   output logic        overrun
);
   // state  | meaning
   // IDLE   | cs_n high, waiting for a synchronized DRDY falling edge
   // SETUP  | cs_n low, CLK_DIV cycles before the first SCLK rise
   // SCK_HI | sclk high half-period
   // SCK_LO | sclk low half-period; miso captured on entry
   // HOLD   | sclk low, cs_n held low before release and frame_done
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SETUP  = 3'd1;
   localparam logic [2:0] SCK_HI = 3'd2;
   localparam logic [2:0] SCK_LO = 3'd3;
   localparam logic [2:0] HOLD   = 3'd4;

   localparam int TW = $clog2(CLK_DIV + 1);
   localparam logic [TW-1:0] T_HALF    = TW'(CLK_DIV - 1);
   localparam logic [TW-1:0] T_HOLD    = TW'(CLK_DIV);
   localparam logic [3:0]    LAST_WORD = 4'(NCH);

   logic          drdy_s1_q, drdy_s1_d;
   logic          drdy_s2_q, drdy_s2_d;
   logic          drdy_s3_q, drdy_s3_d;
   logic          edge_q, edge_d;
   logic [2:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [4:0]    bit_idx_q, bit_idx_d;
   logic [3:0]    word_idx_q, word_idx_d;
   logic [23:0]   shift_q, shift_d;
   logic          word_done_q, word_done_d;
   logic [3:0]    done_word_q, done_word_d;
   logic          sclk_q, sclk_d;
   logic          cs_n_q, cs_n_d;
   logic [31:0]   sample_q, sample_d;
   logic [2:0]    ch_q, ch_d;
   logic          valid_q, valid_d;
   logic [23:0]   status_q, status_d;
   logic          frame_done_q, frame_done_d;
   logic          overrun_q, overrun_d;

   always_comb begin
      drdy_s1_d    = drdy_n;
      drdy_s2_d    = drdy_s1_q;
      drdy_s3_d    = drdy_s2_q;
      edge_d       = drdy_s3_q & ~drdy_s2_q;
      state_d      = state_q;
      timer_d      = timer_q;
      bit_idx_d    = bit_idx_q;
      word_idx_d   = word_idx_q;
      shift_d      = shift_q;
      word_done_d  = 1'b0;
      done_word_d  = done_word_q;
      sclk_d       = sclk_q;
      cs_n_d       = cs_n_q;
      sample_d     = sample_q;
      ch_d         = ch_q;
      valid_d      = 1'b0;
      status_d     = status_q;
      frame_done_d = 1'b0;
      overrun_d    = overrun_q;

      if (!en) begin
         state_d    = IDLE;
         timer_d    = '0;
         bit_idx_d  = '0;
         word_idx_d = '0;
         cs_n_d     = 1'b1;
         sclk_d     = 1'b0;
         overrun_d  = 1'b0;
      end else begin
         // A completed word is published the cycle after its last SCLK low phase.
         if (word_done_q) begin
            if (done_word_q == 4'd0) begin
               status_d = shift_q;
            end else begin
               sample_d = {shift_q[23], shift_q[23], shift_q, 6'b0};
               ch_d     = 3'(done_word_q - 4'd1);
               valid_d  = 1'b1;
            end
         end

         if (edge_q && (state_q != IDLE)) overrun_d = 1'b1;

         case (state_q)
            IDLE: begin
               if (edge_q) begin
                  state_d    = SETUP;
                  cs_n_d     = 1'b0;
                  timer_d    = T_HALF;
                  bit_idx_d  = '0;
                  word_idx_d = '0;
               end
            end
            SETUP: begin
               if (timer_q == '0) begin
                  state_d = SCK_HI;
                  sclk_d  = 1'b1;
                  timer_d = T_HALF;
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
            SCK_HI: begin
               if (timer_q == '0) begin
                  state_d = SCK_LO;
                  sclk_d  = 1'b0;
                  shift_d = {shift_q[22:0], miso};
                  timer_d = T_HALF;
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
            SCK_LO: begin
               if (timer_q == '0) begin
                  if (bit_idx_q == 5'd23) begin
                     word_done_d = 1'b1;
                     done_word_d = word_idx_q;
                     bit_idx_d   = '0;
                     if (word_idx_q == LAST_WORD) begin
                        state_d = HOLD;
                        timer_d = T_HOLD;
                     end else begin
                        word_idx_d = word_idx_q + 4'd1;
                        state_d    = SCK_HI;
                        sclk_d     = 1'b1;
                        timer_d    = T_HALF;
                     end
                  end else begin
                     bit_idx_d = bit_idx_q + 5'd1;
                     state_d   = SCK_HI;
                     sclk_d    = 1'b1;
                     timer_d   = T_HALF;
                  end
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
            HOLD: begin
               if (timer_q == '0) begin
                  state_d      = IDLE;
                  cs_n_d       = 1'b1;
                  frame_done_d = 1'b1;
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cs_n_d  = 1'b1;
               sclk_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drdy_s1_q    <= 1'b1;
         drdy_s2_q    <= 1'b1;
         drdy_s3_q    <= 1'b1;
         edge_q       <= 1'b0;
         state_q      <= IDLE;
         timer_q      <= '0;
         bit_idx_q    <= '0;
         word_idx_q   <= '0;
         shift_q      <= '0;
         word_done_q  <= 1'b0;
         done_word_q  <= '0;
         sclk_q       <= 1'b0;
         cs_n_q       <= 1'b1;
         sample_q     <= '0;
         ch_q         <= '0;
         valid_q      <= 1'b0;
         status_q     <= '0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         drdy_s1_q    <= drdy_s1_d;
         drdy_s2_q    <= drdy_s2_d;
         drdy_s3_q    <= drdy_s3_d;
         edge_q       <= edge_d;
         state_q      <= state_d;
         timer_q      <= timer_d;
         bit_idx_q    <= bit_idx_d;
         word_idx_q   <= word_idx_d;
         shift_q      <= shift_d;
         word_done_q  <= word_done_d;
         done_word_q  <= done_word_d;
         sclk_q       <= sclk_d;
         cs_n_q       <= cs_n_d;
         sample_q     <= sample_d;
         ch_q         <= ch_d;
         valid_q      <= valid_d;
         status_q     <= status_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
      end
   end

   assign sclk       = sclk_q;
   assign cs_n       = cs_n_q;
   assign mosi       = 1'b0;
   assign sample     = sample_q;
   assign ch         = ch_q;
   assign valid      = valid_q;
   assign status     = status_q;
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_ads_frame_reader.sv
// Directed bench for ads_frame_reader: ADC shift-out model, SPI timing monitor,
// and hand-computed frame contents for normal, extreme, overrun and abort cases.
module tb_ads_frame_reader;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic        drdy_n = 1'b1;
   logic        miso = 1'b0;
   logic        sclk, cs_n, mosi, valid, frame_done, overrun;
   logic [31:0] sample;
   logic [2:0]  ch;
   logic [23:0] status;

   int total = 0;
   int bad = 0;

   logic [23:0] words [9];
   logic [31:0] exp_s [8];

   ads_frame_reader #(.CLK_DIV(4), .NCH(8)) dut (
      .clk(clk), .rst(rst), .en(en), .drdy_n(drdy_n), .miso(miso),
      .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .sample(sample), .ch(ch),
      .valid(valid), .status(status), .frame_done(frame_done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // ADC model: shifts the next frame bit out on each SCLK rise, MSB first
   int midx = 0;
   always @(negedge cs_n or posedge sclk) begin
      if (sclk) begin
         if (midx < 216) miso <= words[midx / 24][23 - (midx % 24)];
         midx <= midx + 1;
      end else begin
         midx <= 0;
      end
   end

   // timing / strobe monitor, sampled on the falling clock edge
   int cyc = 0;
   logic cs_prev = 1'b1;
   logic sclk_prev = 1'b0;
   int cs_fall_cnt = 0, cs_fall_cyc = 0, cs_low_total = 0;
   int frame_len = 0, setup_cyc = 0, hold_cyc = 0;
   int rise_cnt = 0, last_rise = 0, last_fall = 0;
   int per_min = 0, per_max = 0;
   int vcnt = 0, fd_cnt = 0, overlap = 0;
   logic [31:0] got_s [64];
   logic [2:0]  got_ch [64];
   int          got_off [64];

   always @(negedge clk) begin
      cyc       <= cyc + 1;
      cs_prev   <= cs_n;
      sclk_prev <= sclk;
      if (!cs_n) cs_low_total <= cs_low_total + 1;
      if (cs_prev && !cs_n) begin
         cs_fall_cnt <= cs_fall_cnt + 1;
         cs_fall_cyc <= cyc;
         rise_cnt    <= 0;
         per_min     <= 999999;
         per_max     <= 0;
      end
      if (!cs_prev && cs_n) begin
         frame_len <= cyc - cs_fall_cyc;
         hold_cyc  <= cyc - last_fall;
      end
      if (!sclk_prev && sclk) begin
         if (rise_cnt == 0) setup_cyc <= cyc - cs_fall_cyc;
         else begin
            if (cyc - last_rise < per_min) per_min <= cyc - last_rise;
            if (cyc - last_rise > per_max) per_max <= cyc - last_rise;
         end
         last_rise <= cyc;
         rise_cnt  <= rise_cnt + 1;
      end
      if (sclk_prev && !sclk) last_fall <= cyc;
      if (valid && vcnt < 64) begin
         got_s[vcnt]   <= sample;
         got_ch[vcnt]  <= ch;
         got_off[vcnt] <= cyc - cs_fall_cyc;
         vcnt          <= vcnt + 1;
      end
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (valid && frame_done) overlap <= overlap + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load_pattern(input int p);
      if (p == 0) begin
         words[0] = 24'hC00000;
         for (int c = 0; c < 8; c++) begin
            words[c + 1] = 24'(24'h000100 * (c + 1));
            exp_s[c]     = 32'(32'h00004000 * (c + 1));
         end
      end else begin
         words[0] = 24'hC00F0F;
         words[1] = 24'h7FFFFF; exp_s[0] = 32'h1FFFFFC0;
         words[2] = 24'h800000; exp_s[1] = 32'hE0000000;
         words[3] = 24'hFFFFFF; exp_s[2] = 32'hFFFFFFC0;
         words[4] = 24'h000000; exp_s[3] = 32'h00000000;
         words[5] = 24'h400000; exp_s[4] = 32'h10000000;
         words[6] = 24'h000001; exp_s[5] = 32'h00000040;
         words[7] = 24'h123456; exp_s[6] = 32'h048D1580;
         words[8] = 24'hABCDEF; exp_s[7] = 32'hEAF37BC0;
      end
   endtask

   // drdy_n falls just before a clock edge E0; cs_n must go low after E3
   task automatic start_frame(input string tag);
      @(negedge clk);
      drdy_n = 1'b0;
      repeat (3) @(negedge clk);
      chk({tag, ".cs_before_e3"}, 32'(cs_n), 32'd1);
      @(negedge clk);
      chk({tag, ".cs_after_e3"}, 32'(cs_n), 32'd0);
      repeat (16) @(negedge clk);
      drdy_n = 1'b1;
   endtask

   task automatic wait_fd(input string tag, input int fbase);
      int n = 0;
      while (fd_cnt == fbase && n < 4000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ".fd_seen"}, 32'(fd_cnt != fbase), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_frame(input string tag, input int vbase, input int fbase, input logic [23:0] exp_stat);
      chk({tag, ".nvalid"}, 32'(vcnt - vbase), 32'd8);
      chk({tag, ".nframe_done"}, 32'(fd_cnt - fbase), 32'd1);
      for (int c = 0; c < 8; c++) begin
         chk($sformatf("%s.ch%0d_idx", tag, c), 32'(got_ch[vbase + c]), 32'(c));
         chk($sformatf("%s.ch%0d_sample", tag, c), got_s[vbase + c], exp_s[c]);
      end
      chk({tag, ".ch0_offset"}, 32'(got_off[vbase]), 32'd389);
      chk({tag, ".ch7_offset"}, 32'(got_off[vbase + 7]), 32'd1733);
      chk({tag, ".status"}, 32'(status), 32'(exp_stat));
      chk({tag, ".frame_len"}, 32'(frame_len), 32'd1737);
      chk({tag, ".sclk_rises"}, 32'(rise_cnt), 32'd216);
      chk({tag, ".sclk_per_min"}, 32'(per_min), 32'd8);
      chk({tag, ".sclk_per_max"}, 32'(per_max), 32'd8);
      chk({tag, ".cs_setup"}, 32'(setup_cyc), 32'd4);
      chk({tag, ".cs_hold_ge4"}, 32'(hold_cyc >= 4), 32'd1);
      chk({tag, ".valid_fd_overlap"}, 32'(overlap), 32'd0);
      chk({tag, ".mosi"}, 32'(mosi), 32'd0);
   endtask

   initial begin
      int vb, fb, cb, n;
      load_pattern(0);

      // reset and idle
      repeat (2) @(negedge clk);
      chk("rst.sclk", 32'(sclk), 32'd0);
      chk("rst.cs_n", 32'(cs_n), 32'd1);
      chk("rst.mosi", 32'(mosi), 32'd0);
      chk("rst.sample", sample, 32'd0);
      chk("rst.ch", 32'(ch), 32'd0);
      chk("rst.valid", 32'(valid), 32'd0);
      chk("rst.status", 32'(status), 32'd0);
      chk("rst.frame_done", 32'(frame_done), 32'd0);
      chk("rst.overrun", 32'(overrun), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      chk("idle.cs_low_cycles", 32'(cs_low_total), 32'd0);
      chk("idle.cs_n", 32'(cs_n), 32'd1);

      // single frame, ramp pattern
      vb = vcnt; fb = fd_cnt;
      start_frame("f1");
      wait_fd("f1", fb);
      check_frame("f1", vb, fb, 24'hC00000);
      chk("f1.overrun", 32'(overrun), 32'd0);
      chk("f1.sample_hold", sample, 32'h00020000);
      chk("f1.ch_hold", 32'(ch), 32'd7);

      // sign and extremes
      load_pattern(1);
      repeat (10) @(negedge clk);
      vb = vcnt; fb = fd_cnt;
      start_frame("ext");
      wait_fd("ext", fb);
      check_frame("ext", vb, fb, 24'hC00F0F);
      chk("ext.overrun", 32'(overrun), 32'd0);

      // overrun: second DRDY edge 500 cycles into the frame
      load_pattern(0);
      repeat (10) @(negedge clk);
      vb = vcnt; fb = fd_cnt;
      start_frame("ovr");
      repeat (480) @(negedge clk);
      drdy_n = 1'b0;
      repeat (20) @(negedge clk);
      drdy_n = 1'b1;
      chk("ovr.flag_set", 32'(overrun), 32'd1);
      wait_fd("ovr", fb);
      check_frame("ovr", vb, fb, 24'hC00000);
      cb = cs_fall_cnt;
      repeat (300) @(negedge clk);
      chk("ovr.no_second_frame", 32'(cs_fall_cnt - cb), 32'd0);
      chk("ovr.sticky", 32'(overrun), 32'd1);

      // abort after channel 2 valid
      vb = vcnt; fb = fd_cnt;
      start_frame("abt");
      n = 0;
      while (!(valid === 1'b1 && ch === 3'd2) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("abt.ch2_seen", 32'(n < 3000), 32'd1);
      chk("abt.overrun_before", 32'(overrun), 32'd1);
      en = 1'b0;
      @(negedge clk);
      chk("abt.cs_n", 32'(cs_n), 32'd1);
      chk("abt.sclk", 32'(sclk), 32'd0);
      chk("abt.overrun_cleared", 32'(overrun), 32'd0);
      chk("abt.sample_kept", sample, 32'h0000C000);
      cb = cs_fall_cnt;
      @(negedge clk);
      drdy_n = 1'b0;
      repeat (30) @(negedge clk);
      drdy_n = 1'b1;
      repeat (170) @(negedge clk);
      chk("abt.valid_count", 32'(vcnt - vb), 32'd3);
      chk("abt.no_frame_done", 32'(fd_cnt - fb), 32'd0);
      chk("abt.edge_ignored", 32'(cs_fall_cnt - cb), 32'd0);
      en = 1'b1;
      load_pattern(1);
      repeat (10) @(negedge clk);
      vb = vcnt; fb = fd_cnt;
      start_frame("rec");
      wait_fd("rec", fb);
      check_frame("rec", vb, fb, 24'hC00F0F);

      // asynchronous reset mid-frame
      start_frame("rmf");
      repeat (300) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rmf.cs_n", 32'(cs_n), 32'd1);
      chk("rmf.sclk", 32'(sclk), 32'd0);
      chk("rmf.sample", sample, 32'd0);
      chk("rmf.status", 32'(status), 32'd0);
      chk("rmf.ch", 32'(ch), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("rmf.idle_after", 32'(cs_n), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
